vc_arbiter: RTL

Read side of the VC0/VC1 transmit FIFOs. Pops one word per grant from a non-empty virtual-channel FIFO (VC0 strict priority over VC1) and routes it to one of two destination FIFOs (D0/D1), based on a destination bit in the word. Honours almost-full backpressure from the destinations. Sits between the VC FIFOs and the D0/D1 FIFOs in the transmission layer.

---
 rtl/vc_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/vc_arbiter.sv
// rtl/vc_arbiter.sv - VC0/VC1 FIFO read arbiter routing words to the D0/D1 destination FIFOs
module vc_arbiter #(
  parameter int data_width = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_vc0,
  input  logic                  empty_vc1,
  input  logic [data_width-1:0] data_vc0,
  input  logic [data_width-1:0] data_vc1,
  input  logic                  almost_full_d0,
  input  logic                  almost_full_d1,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [data_width-1:0] data_out,
  output logic [4:0]            cnt_d0,
  output logic [4:0]            cnt_d1,
  output logic [1:0]            state,
  output logic                  idle
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  gap0_q, gap1_q;
  logic                  push_d0_q, push_d1_q, idle_q;
  logic [data_width-1:0] data_q;
  logic [4:0]            cnt0_q, cnt1_q;

  logic                  run, elig0, elig1, pop0, pop1, any_pop, wdest;
  logic [data_width-1:0] word;

  // The peek word is stale for one cycle after a pop, so a VC just popped must sit out a cycle.
  always_comb begin
    run     = reset && init && (state_q == ST_IDLE || state_q == ST_ACTIVE);
    elig0   = run && !empty_vc0 && !gap0_q &&
              !(data_vc0[data_width-1] ? almost_full_d1 : almost_full_d0);
    elig1   = run && !empty_vc1 && !gap1_q &&
              !(data_vc1[data_width-1] ? almost_full_d1 : almost_full_d0);
    pop0    = elig0;
    pop1    = elig1 && !elig0;
    any_pop = pop0 || pop1;
    word    = pop0 ? data_vc0 : data_vc1;
    wdest   = word[data_width-1];
  end

  always_comb begin
    state_d = state_q;
    if (!reset) begin
      state_d = ST_RESET;
    end else if (!init) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_RESET: state_d = ST_INIT;
        ST_INIT:  state_d = ST_IDLE;
        default:  state_d = (elig0 || elig1) ? ST_ACTIVE : ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  // Dropping init clears the datapath exactly like reset; a word popped on that edge is lost.
  always_ff @(posedge clk) begin
    if (!reset || !init) begin
      gap0_q    <= 1'b0;
      gap1_q    <= 1'b0;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      data_q    <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      idle_q    <= 1'b0;
    end else begin
      gap0_q    <= pop0;
      gap1_q    <= pop1;
      push_d0_q <= any_pop && !wdest;
      push_d1_q <= any_pop && wdest;
      if (any_pop) begin
        data_q <= word;
      end
      if (any_pop && !wdest) begin
        cnt0_q <= cnt0_q + 5'd1;
      end
      if (any_pop && wdest) begin
        cnt1_q <= cnt1_q + 5'd1;
      end
      idle_q    <= (state_d == ST_IDLE);
    end
  end

  assign pop_vc0  = pop0;
  assign pop_vc1  = pop1;
  assign push_d0  = push_d0_q;
  assign push_d1  = push_d1_q;
  assign data_out = data_q;
  assign cnt_d0   = cnt0_q;
  assign cnt_d1   = cnt1_q;
  assign state    = state_q;
  assign idle     = idle_q;

endmodule
